// File: rtl/conv2_bias_sequencer.sv
// Fetches one packed bias vector per conv2 output batch and adds it lane-wise, with saturation,
// to that batch's accumulator stream; single output register, 1 vector/cycle when not stalled.
module conv2_bias_sequencer #(
  parameter int OUT_NUM   = 16,
  parameter int OUT_BATCH = 4,
  parameter int W_BATCH   = 2,
  parameter int WD_BIAS   = 34,
  parameter int WD_ACC    = 40,
  parameter int W_PIX     = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [W_PIX-1:0]           cfg_pix_num,
  output logic                       busy,
  output logic                       done,
  output logic [W_BATCH-1:0]         rom_aa,
  output logic                       rom_cena,
  input  logic [OUT_NUM*WD_BIAS-1:0] rom_qa,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OUT_NUM*WD_ACC-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_NUM*WD_ACC-1:0]  out_data,
  output logic [W_BATCH-1:0]         out_batch,
  output logic                       out_last
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [W_BATCH-1:0] LAST_BATCH = W_BATCH'(OUT_BATCH - 1);

  logic [2:0]                 state_q, state_d;
  logic [W_BATCH-1:0]         batch_q, batch_d;
  logic [W_PIX-1:0]           pix_q, pix_d;
  logic [W_PIX-1:0]           pix_num_q, pix_num_d;
  logic [OUT_NUM*WD_BIAS-1:0] bias_q;
  logic                       out_valid_q;
  logic                       out_last_q;
  logic [W_BATCH-1:0]         out_batch_q;
  logic [OUT_NUM*WD_ACC-1:0]  out_data_q;
  logic [OUT_NUM*WD_ACC-1:0]  sum_sat;
  logic                       in_fire;
  logic                       out_fire;
  logic                       is_last;

  // Overflow shows up as differing top two bits of the WD_ACC+1 sum; clamp toward the sign.
  for (genvar g = 0; g < OUT_NUM; g++) begin : g_lane
    logic [WD_ACC:0] acc_ext;
    logic [WD_ACC:0] bias_ext;
    logic [WD_ACC:0] sum;

    assign acc_ext  = {in_data[g*WD_ACC + WD_ACC - 1], in_data[g*WD_ACC +: WD_ACC]};
    assign bias_ext = {{(WD_ACC + 1 - WD_BIAS){bias_q[g*WD_BIAS + WD_BIAS - 1]}},
                       bias_q[g*WD_BIAS +: WD_BIAS]};
    assign sum      = acc_ext + bias_ext;
    assign sum_sat[g*WD_ACC +: WD_ACC] = (sum[WD_ACC] == sum[WD_ACC-1]) ? sum[WD_ACC-1:0] :
                                         {sum[WD_ACC], {(WD_ACC-1){~sum[WD_ACC]}}};
  end

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign is_last  = (pix_q == (pix_num_q - W_PIX'(1)));

  always_comb begin
    state_d   = state_q;
    batch_d   = batch_q;
    pix_d     = pix_q;
    pix_num_d = pix_num_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pix_num_d = cfg_pix_num;
          batch_d   = '0;
          pix_d     = '0;
          state_d   = (cfg_pix_num == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_RUN;
      S_RUN: begin
        if (in_fire) begin
          pix_d = pix_q + W_PIX'(1);
          if (is_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The next bias fetch waits until the last beat of this batch has left the output register.
        if (out_fire) begin
          pix_d = '0;
          if (batch_q == LAST_BATCH) begin
            state_d = S_DONE;
          end else begin
            batch_d = batch_q + W_BATCH'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      batch_q     <= '0;
      pix_q       <= '0;
      pix_num_q   <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_batch_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      batch_q   <= batch_d;
      pix_q     <= pix_d;
      pix_num_q <= pix_num_d;
      if (state_q == S_WAIT) bias_q <= rom_qa;
      if (in_fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sum_sat;
        out_batch_q <= batch_q;
        out_last_q  <= is_last;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rom_cena  = (state_q != S_FETCH);
  assign rom_aa    = batch_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_batch = out_batch_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv2_bias_sequencer.sv
// Randomized bench for conv2_bias_sequencer: ROM model, expected-beat queue built from
// per-batch saturating bias addition, and one negedge compare process.
module tb_conv2_bias_sequencer;

  localparam int OUT_NUM   = 16;
  localparam int OUT_BATCH = 4;
  localparam int W_BATCH   = 2;
  localparam int WD_BIAS   = 34;
  localparam int WD_ACC    = 40;
  localparam int W_PIX     = 16;
  localparam int VW        = OUT_NUM*WD_ACC;
  localparam int BW        = OUT_NUM*WD_BIAS;

  localparam logic [WD_ACC-1:0]  ACC_MAX_V  = {1'b0, {(WD_ACC-1){1'b1}}};
  localparam logic [WD_ACC-1:0]  ACC_MIN_V  = {1'b1, {(WD_ACC-1){1'b0}}};
  localparam logic [WD_BIAS-1:0] BIAS_MAX_V = {1'b0, {(WD_BIAS-1){1'b1}}};
  localparam logic [WD_BIAS-1:0] BIAS_MIN_V = {1'b1, {(WD_BIAS-1){1'b0}}};
  localparam longint ACC_MAX_L = (longint'(1) << (WD_ACC-1)) - 1;
  localparam longint ACC_MIN_L = -ACC_MAX_L - 1;

  typedef struct {
    logic [VW-1:0]      data;
    logic [W_BATCH-1:0] batch;
    logic               last;
  } beat_t;

  logic               clk;
  logic               rstn;
  logic               start;
  logic [W_PIX-1:0]   cfg_pix_num;
  logic               busy;
  logic               done;
  logic [W_BATCH-1:0] rom_aa;
  logic               rom_cena;
  logic [BW-1:0]      rom_qa;
  logic               in_valid;
  logic               in_ready;
  logic [VW-1:0]      in_data;
  logic               out_valid;
  logic               out_ready;
  logic [VW-1:0]      out_data;
  logic [W_BATCH-1:0] out_batch;
  logic               out_last;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [BW-1:0]      rom_mem [OUT_BATCH];
  logic [VW-1:0]      in_q[$];
  logic [VW-1:0]      got_q[$];
  logic [W_BATCH-1:0] rom_reads[$];
  beat_t              exp_q[$];

  conv2_bias_sequencer #(
    .OUT_NUM(OUT_NUM), .OUT_BATCH(OUT_BATCH), .W_BATCH(W_BATCH),
    .WD_BIAS(WD_BIAS), .WD_ACC(WD_ACC), .W_PIX(W_PIX)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_pix_num(cfg_pix_num),
    .busy(busy), .done(done), .rom_aa(rom_aa), .rom_cena(rom_cena), .rom_qa(rom_qa),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_batch(out_batch), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bias ROM: registered read, data valid the cycle after the enable cycle.
  always @(posedge clk) if (!rom_cena) rom_qa <= rom_mem[rom_aa];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic longint lane_acc(input logic [VW-1:0] v, input int i);
    logic signed [WD_ACC-1:0] x;
    x = v[i*WD_ACC +: WD_ACC];
    return longint'(x);
  endfunction

  function automatic longint lane_bias(input logic [BW-1:0] v, input int i);
    logic signed [WD_BIAS-1:0] x;
    x = v[i*WD_BIAS +: WD_BIAS];
    return longint'(x);
  endfunction

  function automatic longint sat_add(input longint a, input longint b);
    longint s;
    s = a + b;
    if (s > ACC_MAX_L) return ACC_MAX_L;
    if (s < ACC_MIN_L) return ACC_MIN_L;
    return s;
  endfunction

  function automatic logic [WD_BIAS-1:0] to_bias(input longint v);
    return v[WD_BIAS-1:0];
  endfunction

  function automatic logic [WD_ACC-1:0] rand_acc();
    logic [63:0] r;
    int m;
    r = {$urandom, $urandom};
    m = $urandom_range(0, 5);
    if (m == 0) return ACC_MAX_V - WD_ACC'(r[3:0]);
    if (m == 1) return ACC_MIN_V + WD_ACC'(r[3:0]);
    return r[WD_ACC-1:0];
  endfunction

  function automatic logic [VW-1:0] rand_acc_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < OUT_NUM; i++) v[i*WD_ACC +: WD_ACC] = rand_acc();
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_bias_vec();
    logic [BW-1:0] v;
    logic [63:0] r;
    int m;
    for (int i = 0; i < OUT_NUM; i++) begin
      r = {$urandom, $urandom};
      m = $urandom_range(0, 5);
      if (m == 0)      v[i*WD_BIAS +: WD_BIAS] = BIAS_MAX_V - WD_BIAS'(r[3:0]);
      else if (m == 1) v[i*WD_BIAS +: WD_BIAS] = BIAS_MIN_V + WD_BIAS'(r[3:0]);
      else             v[i*WD_BIAS +: WD_BIAS] = r[WD_BIAS-1:0];
    end
    return v;
  endfunction

  task automatic fill_pass(input int pix);
    in_q.delete();
    for (int b = 0; b < OUT_BATCH; b++) rom_mem[b] = rand_bias_vec();
    for (int k = 0; k < OUT_BATCH*pix; k++) in_q.push_back(rand_acc_vec());
  endtask

  // Beat k of a pass belongs to batch k/pix and gets that batch's bias.
  task automatic build_exp(input int pix);
    exp_q.delete();
    for (int k = 0; k < in_q.size(); k++) begin
      beat_t e;
      int b;
      b = k / pix;
      for (int i = 0; i < OUT_NUM; i++)
        e.data[i*WD_ACC +: WD_ACC] = WD_ACC'(sat_add(lane_acc(in_q[k], i), lane_bias(rom_mem[b], i)));
      e.batch = W_BATCH'(b);
      e.last  = ((k % pix) == (pix - 1));
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {busy, done, rom_cena, in_ready, out_valid, out_last}, 6'b001000);
    check({tag, "_aa_batch"}, {rom_aa, out_batch}, '0);
    check_vec({tag, "_data"}, out_data, '0);
  endtask

  beat_t              mon_e;
  bit                 prev_hold = 0;
  bit                 prev_cena_low = 0;
  logic [VW-1:0]      prev_data;
  logic [W_BATCH-1:0] prev_batch;
  logic               prev_last;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_hold = 0;
      prev_cena_low = 0;
    end else begin
      if (prev_hold) begin
        check_vec("hold_data", out_data, prev_data);
        check("hold_meta", {out_valid, out_batch, out_last}, {1'b1, prev_batch, prev_last});
      end
      if (out_valid && !out_ready) check("in_ready_blocked", in_ready, 0);
      if (in_ready) check("in_ready_only_busy", busy, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got batch %0d with no beat expected", out_batch);
        end else begin
          mon_e = exp_q.pop_front();
          check_vec("out_data", out_data, mon_e.data);
          check("out_batch_last", {out_batch, out_last}, {mon_e.batch, mon_e.last});
        end
        got_q.push_back(out_data);
      end
      if (!rom_cena) begin
        rom_reads.push_back(rom_aa);
        check("rom_cena_single_cycle", prev_cena_low, 0);
      end
      if (done) done_cnt++;
      prev_hold     = out_valid && !out_ready;
      prev_data     = out_data;
      prev_batch    = out_batch;
      prev_last     = out_last;
      prev_cena_low = !rom_cena;
    end
  end

  // Cycle 0 of the loop is the first cycle after the edge that samples start.
  task automatic run_pass(input int pix, input int vld_pct, input int rdy_pct, input int stall_at,
                          input int glitch_cyc, input int abort_rd,
                          output int first_rdy, output int first_rom, output int done_cyc);
    int k, cyc, abort_cnt;
    bit seen_done, acc, aborted;
    k = 0; cyc = 0; abort_cnt = 0;
    seen_done = 0; aborted = 0;
    first_rdy = -1; first_rom = -1; done_cyc = -1;
    build_exp(pix);
    rom_reads.delete();
    got_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    cfg_pix_num = W_PIX'(pix);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen_done && !aborted && cyc < 4000) begin
      start = (cyc == glitch_cyc);
      cfg_pix_num = start ? W_PIX'(pix + 2) : W_PIX'(pix);
      if (k < in_q.size()) begin
        if (!in_valid && $urandom_range(0, 99) < vld_pct) in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      in_data = in_valid ? in_q[k] : rand_acc_vec();
      out_ready = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) ? 1'b0 :
                  ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (in_ready && first_rdy < 0) first_rdy = cyc;
      if (!rom_cena && first_rom < 0) first_rom = cyc;
      if (done) begin
        seen_done = 1;
        done_cyc = cyc;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        in_valid = 1'b0;
      end
      if (abort_rd > 0 && rom_reads.size() == abort_rd) begin
        abort_cnt++;
        if (abort_cnt == 4) begin
          check("abort_in_batch", {out_valid, out_batch}, {1'b1, W_BATCH'(abort_rd - 1)});
          #2;
          rstn = 1'b0;
          #1;
          check_reset_vals("abort");
          exp_q.delete();
          aborted = 1;
          in_valid = 1'b0;
          start = 1'b0;
          @(negedge clk);
          rstn = 1'b1;
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b0;
    cfg_pix_num = W_PIX'(pix);
    if (!seen_done && !aborted) begin
      checks++;
      errors++;
      $display("FAIL pass_timeout: pix=%0d sent %0d of %0d beats, no done", pix, k, in_q.size());
    end
    if (!aborted) begin
      repeat (3) @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_pulses", done_cnt, 1);
      check("beats_sent", k, in_q.size());
      check("beats_left", exp_q.size(), 0);
      check("rom_read_count", rom_reads.size(), (pix == 0) ? 0 : OUT_BATCH);
      foreach (rom_reads[i]) check("rom_aa_order", rom_reads[i], i);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, fm, fd, pix;
    logic [VW-1:0] tv;
    logic [BW-1:0] tb;
    rstn = 1'b0; start = 1'b0; cfg_pix_num = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int b = 0; b < OUT_BATCH; b++) rom_mem[b] = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rstn = 1'b1;

    // Directed pass: known sums in batch 0, both saturation directions in batch 1.
    fill_pass(2);
    for (int i = 0; i < OUT_NUM; i++) tv[i*WD_ACC +: WD_ACC] = WD_ACC'(200000000);
    in_q[0] = tv;
    in_q[1] = tv;
    tv = in_q[2];
    tv[0 +: WD_ACC]      = ACC_MAX_V - WD_ACC'(9);
    tv[WD_ACC +: WD_ACC] = ACC_MIN_V;
    in_q[2] = tv;
    tb = rom_mem[0];
    tb[0 +: WD_BIAS]         = to_bias(-167012672);
    tb[3*WD_BIAS +: WD_BIAS] = to_bias(491355872);
    rom_mem[0] = tb;
    tb = rom_mem[1];
    tb[0 +: WD_BIAS]       = to_bias(100);
    tb[WD_BIAS +: WD_BIAS] = to_bias(-5);
    rom_mem[1] = tb;
    run_pass(2, 100, 100, -1, -1, 0, fr, fm, fd);
    check("first_rom_read_cycle", fm, 0);
    check("first_in_ready_cycle", fr, 2);
    check("passA_beats", got_q.size(), 2*OUT_BATCH);
    if (got_q.size() >= 3) begin
      check("lit_b0_lane0", lane_acc(got_q[0], 0), 64'sd32987328);
      check("lit_b0_lane3", lane_acc(got_q[0], 3), 64'sd691355872);
      check("lit_b1_lane3", lane_acc(got_q[1], 3), 64'sd691355872);
      check("lit_sat_pos", lane_acc(got_q[2], 0), 64'sd549755813887);
      check("lit_sat_neg", lane_acc(got_q[2], 1), -64'sd549755813888);
    end else begin
      checks++;
      errors++;
      $display("FAIL passA_literals: got %0d beats, need at least 3", got_q.size());
    end

    // Continuous streaming, 3 pixels per batch.
    fill_pass(3);
    run_pass(3, 100, 100, -1, -1, 0, fr, fm, fd);
    check("passB_beats", got_q.size(), 3*OUT_BATCH);

    // Backpressure stretch mid-batch and a start pulse while running.
    fill_pass(6);
    run_pass(6, 100, 100, 6, 4, 0, fr, fm, fd);

    // Zero pixels: straight to done, no ROM access.
    fill_pass(0);
    run_pass(0, 100, 100, -1, -1, 0, fr, fm, fd);
    check("zero_pix_done_cycle", fd, 0);

    for (int r = 0; r < 6; r++) begin
      pix = $urandom_range(1, 7);
      fill_pass(pix);
      run_pass(pix, 60, 60, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : -1,
               -1, 0, fr, fm, fd);
    end

    // Reset during batch 2, then a complete pass from batch 0.
    fill_pass(4);
    run_pass(4, 100, 100, -1, -1, 3, fr, fm, fd);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);
    fill_pass(3);
    run_pass(3, 80, 70, -1, -1, 0, fr, fm, fd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
